// File: rtl/core_hcu_fwd_pkg.sv
// Shared constants and types for the hazard-control unit.
//   FWD_* : operand-forward select encodings driven on FWD_SEL
//   hcu_state_e : memory-wait FSM states
//   src_match_t : per-source {ex, mem, wb} producer match vector
package core_hcu_fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;  // register file
  localparam logic [1:0] FWD_EXMEM = 2'd1;  // EX/MEM ALU result
  localparam logic [1:0] FWD_WB    = 2'd2;  // WB-stage write data
  localparam logic [1:0] FWD_WBQ   = 2'd3;  // WB write data held from last cycle

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } hcu_state_e;

  typedef struct packed {
    logic ex;
    logic mem;
    logic wb;
  } src_match_t;

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [1:0] fwd_encode(input src_match_t m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (m.wb)  sel = FWD_WBQ;
    if (m.mem) sel = FWD_WB;
    if (m.ex)  sel = FWD_EXMEM;
    return sel;
  endfunction

endpackage

// File: rtl/core_hcu_match.sv
// Per-source RAW comparator against the EX, MEM and WB destinations.
//   i_raddr/i_rvalid          : ID-stage source address and read flag
//   i_*_waddr/i_*_wvalid      : destination and write flag of each stage
//   o_match                   : {ex, mem, wb} match vector; x0 never matches
module core_hcu_match
  import core_hcu_fwd_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_raddr,
  input  logic            i_rvalid,
  input  logic [RA_W-1:0] i_ex_waddr,
  input  logic            i_ex_wvalid,
  input  logic [RA_W-1:0] i_mem_waddr,
  input  logic            i_mem_wvalid,
  input  logic [RA_W-1:0] i_wb_waddr,
  input  logic            i_wb_wvalid,
  output logic [2:0]      o_match
);

  logic w_live;

  assign w_live = i_rvalid && (i_raddr != '0);

  always_comb begin
    o_match    = '0;
    o_match[2] = w_live && i_ex_wvalid  && (i_ex_waddr  == i_raddr);
    o_match[1] = w_live && i_mem_wvalid && (i_mem_waddr == i_raddr);
    o_match[0] = w_live && i_wb_wvalid  && (i_wb_waddr  == i_raddr);
  end

endmodule

// File: rtl/core_hcu_fwd.sv
// Hazard-control unit for the 5-stage RV32I pipeline.
//   CLK/NRST                     : clock, synchronous active-low reset
//   ID_RADDR/ID_RVALID           : ID source operands
//   EX/MEM/WB_WADDR, *_WVALID    : in-flight destinations
//   EX_ISLOAD, REDIRECT          : load in EX, taken control transfer in EX
//   IMEM_DONE, DMEM_START/DONE   : memory handshakes
//   PC_WRITE, *_EN, *_FLUSH      : pipeline-register controls (combinational)
//   FWD_SEL                      : registered, EX-aligned forward selects
//   STALL_CNT, FLUSH_CNT         : saturating performance counters
module core_hcu_fwd
  import core_hcu_fwd_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [NUM_SRC*RA_W-1:0] ID_RADDR,
  input  logic [NUM_SRC-1:0]      ID_RVALID,
  input  logic [RA_W-1:0]         EX_WADDR,
  input  logic [RA_W-1:0]         MEM_WADDR,
  input  logic [RA_W-1:0]         WB_WADDR,
  input  logic                    EX_WVALID,
  input  logic                    MEM_WVALID,
  input  logic                    WB_WVALID,
  input  logic                    EX_ISLOAD,
  input  logic                    REDIRECT,
  input  logic                    IMEM_DONE,
  input  logic                    DMEM_START,
  input  logic                    DMEM_DONE,
  output logic                    PC_WRITE,
  output logic                    IFID_EN,
  output logic                    IFID_FLUSH,
  output logic                    IDEX_EN,
  output logic                    IDEX_FLUSH,
  output logic                    EXMEM_EN,
  output logic                    EXMEM_FLUSH,
  output logic                    MEMWB_EN,
  output logic [2*NUM_SRC-1:0]    FWD_SEL,
  output logic [CNT_W-1:0]        STALL_CNT,
  output logic [CNT_W-1:0]        FLUSH_CNT
);

  src_match_t             w_match [NUM_SRC];
  logic [2*NUM_SRC-1:0]   w_fwd_sel;
  logic                   w_hazard;
  logic                   r_imem_q, r_dpend, r_dmem_q;
  logic                   w_imem_ok, w_dmem_ok, w_advance;
  hcu_state_e             r_state, w_state_nxt;
  logic                   w_stall_ev, w_flush_ev;
  logic [2*NUM_SRC-1:0]   r_fwd_sel;
  logic [CNT_W-1:0]       r_stall_cnt, r_flush_cnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    core_hcu_match #(.RA_W(RA_W)) u_match (
      .i_raddr      (ID_RADDR[g*RA_W +: RA_W]),
      .i_rvalid     (ID_RVALID[g]),
      .i_ex_waddr   (EX_WADDR),
      .i_ex_wvalid  (EX_WVALID),
      .i_mem_waddr  (MEM_WADDR),
      .i_mem_wvalid (MEM_WVALID),
      .i_wb_waddr   (WB_WADDR),
      .i_wb_wvalid  (WB_WVALID),
      .o_match      (w_match[g])
    );
  end

  // Without forwarding every in-flight producer is a hazard and selects stay RF.
  always_comb begin
    w_fwd_sel = '0;
    w_hazard  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (FWD_EN != 0) begin
        w_fwd_sel[2*i +: 2] = fwd_encode(w_match[i]);
        w_hazard = w_hazard | (w_match[i].ex & EX_ISLOAD);
      end else begin
        w_hazard = w_hazard | (w_match[i] != '0);
      end
    end
  end

  // Latches can only be set on a non-advancing cycle, which always moves the
  // FSM to WAIT, so gating them with WAIT is equivalent and keeps RUN clean.
  assign w_imem_ok = IMEM_DONE | ((r_state == ST_WAIT) & r_imem_q);
  assign w_dmem_ok = ~(DMEM_START | ((r_state == ST_WAIT) & r_dpend))
                   | DMEM_DONE | ((r_state == ST_WAIT) & r_dmem_q);
  assign w_advance = w_imem_ok & w_dmem_ok;

  always_ff @(posedge CLK) begin
    if (!NRST || w_advance) begin
      r_imem_q <= 1'b0;
      r_dpend  <= 1'b0;
      r_dmem_q <= 1'b0;
    end else begin
      r_imem_q <= r_imem_q | IMEM_DONE;
      r_dpend  <= r_dpend  | DMEM_START;
      r_dmem_q <= r_dmem_q | DMEM_DONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (!w_advance) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_advance)  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    PC_WRITE    = 1'b0;
    IFID_EN     = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_EN     = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_EN    = 1'b0;
    EXMEM_FLUSH = 1'b0;
    MEMWB_EN    = 1'b0;
    w_stall_ev  = 1'b0;
    w_flush_ev  = 1'b0;
    if (!NRST) begin
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      EXMEM_FLUSH = 1'b1;
    end else if (!w_advance) begin
      // Freeze: everything holds, including a pending REDIRECT in IDEX.
      w_stall_ev = 1'b1;
    end else if (REDIRECT) begin
      PC_WRITE   = 1'b1;
      IFID_EN    = 1'b1;
      IDEX_EN    = 1'b1;
      EXMEM_EN   = 1'b1;
      MEMWB_EN   = 1'b1;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      w_flush_ev = 1'b1;
    end else if (w_hazard) begin
      IDEX_EN    = 1'b1;
      IDEX_FLUSH = 1'b1;
      EXMEM_EN   = 1'b1;
      MEMWB_EN   = 1'b1;
      w_stall_ev = 1'b1;
    end else begin
      PC_WRITE = 1'b1;
      IFID_EN  = 1'b1;
      IDEX_EN  = 1'b1;
      EXMEM_EN = 1'b1;
      MEMWB_EN = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST || IDEX_FLUSH) r_fwd_sel <= '0;
    else if (IDEX_EN)        r_fwd_sel <= w_fwd_sel;
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_ev && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign FWD_SEL   = r_fwd_sel;
  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

endmodule

// File: doc/core_hcu_fwd.md
# core_hcu_fwd

Parametrised hazard-control unit for the 5-stage RV32I pipeline.
- Replaces the stall-only HCU and sits beside the pipeline registers in the core controller.
- Per pipeline register, drives enable, flush and the PC write strobe.
- Generates registered operand-forwarding selects for N source operands, with a mode that disables forwarding and stalls instead.
- Latches instruction-memory and data-memory completion across multi-cycle freezes, and keeps saturating stall/flush counters.

## Interface
Parameters:
- RA_W, 5, register-address width
- NUM_SRC, 2, number of ID-stage source operands
- FWD_EN, 1, 1 = forward and stall only on load-use; 0 = stall on any RAW hazard
- CNT_W, 16, width of the performance counters

Ports:
- CLK  in  1  clock, single domain
- NRST  in  1  reset, synchronous, active-low
- ID_RADDR  in  NUM_SRC*RA_W  ID-stage source addresses, source i at [i*RA_W +: RA_W]
- ID_RVALID  in  NUM_SRC  source i is actually read
- EX_WADDR, MEM_WADDR, WB_WADDR  in  RA_W each  destination register of the instruction in EX, MEM and WB
- EX_WVALID, MEM_WVALID, WB_WVALID  in  1 each  that stage writes a register
- EX_ISLOAD  in  1  the EX-stage instruction is a load
- REDIRECT  in  1  EX resolves a taken branch, JAL or JALR
- IMEM_DONE  in  1  fetch data valid pulse
- DMEM_START  in  1  load/store issued this cycle (MEM stage)
- DMEM_DONE  in  1  data-memory completion pulse
- PC_WRITE  out  1  PC update strobe
- IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH, EXMEM_EN, EXMEM_FLUSH, MEMWB_EN  out  1 each  pipeline-register controls
- FWD_SEL  out  2*NUM_SRC  registered, EX-aligned forward select
- STALL_CNT, FLUSH_CNT  out  CNT_W each  saturating counters

## Operation
Source matching:
- Source i matches stage S when ID_RVALID[i], S_WVALID, S_WADDR == source address, and the address is nonzero.
- x0 never matches.

Forward-select encoding (define.vh):
- FWD_RF = 0: no forward, use the register file.
- FWD_EXMEM = 1: EX/MEM ALU result.
- FWD_WB = 2: WB-stage write data.
- FWD_WBQ = 3: the WB write data retained from the previous cycle.
- Mapping from matches: EX match → 1, MEM match → 2, WB match → 3, otherwise 0. The youngest match wins (EX > MEM > WB).

Hazard detection:
- FWD_EN=1: a load-use hazard is any source matching EX while EX_ISLOAD=1.
- FWD_EN=0: any match in EX, MEM or WB is a hazard, and FWD_SEL is forced to 0.

Memory FSM:
- States: RUN, WAIT.
- Flag imem_q latches IMEM_DONE. Flag dpend latches DMEM_START; dmem_q latches DMEM_DONE.
- advance = (IMEM_DONE | imem_q) & (!(DMEM_START | dpend) | DMEM_DONE | dmem_q).
- RUN → WAIT when !advance. WAIT → RUN when advance.
- On advance, all latches clear. A START and DONE in the same cycle count as complete.

Control priority (highest first):
1. Reset: all EN=0, all FLUSH=1, PC_WRITE=0.
2. Freeze (!advance): all EN=0, all FLUSH=0, PC_WRITE=0. REDIRECT is held by the frozen IDEX register and acted on at advance.
3. REDIRECT: all EN=1, IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1. This overrides a simultaneous hazard, because the younger instruction is flushed.
4. Hazard: PC_WRITE=0, IFID_EN=0, IDEX_FLUSH=1 (bubble), EXMEM_EN=1, MEMWB_EN=1.
5. Normal: all EN=1, all FLUSH=0, PC_WRITE=1.

FWD_SEL register:
- Loads the computed select when IDEX_EN & !IDEX_FLUSH.
- Clears to 0 on IDEX_FLUSH.
- Holds during freeze.

Counters:
- STALL_CNT increments on each freeze or hazard cycle.
- FLUSH_CNT increments on each REDIRECT action.
- Both saturate at all-ones and clear on reset.

## Timing
- Enable and flush outputs are combinational from inputs and state, resolved in the same cycle.
- FWD_SEL has 1-cycle latency: it is computed in ID and valid while the consumer is in EX.
- A load-use hazard costs exactly 1 bubble. The consumer then sees FWD_SEL=2.
- Reset values: state RUN; imem_q, dpend, dmem_q = 0; FWD_SEL = 0; counters = 0.
- Reset asserted mid-WAIT drops pending memory latches at the next edge.
- With FWD_EN=0, a dependency on EX stalls 3 cycles, until the writer has left WB.

## Structure
- Shared constants in define.vh: FWD_RF, FWD_EXMEM, FWD_WB, FWD_WBQ, and the HCU state encodings.
- One sub-module, core_hcu_match: per-source comparator returning an {ex, mem, wb} match vector. Instantiate it NUM_SRC times in a generate loop.
- The FSM, priority logic and counters live in core_hcu_fwd.

## Test plan
1. `add x5,..` followed by `add x6,x5,x5` (FWD_EN=1): no stall, PC_WRITE=1 every cycle, FWD_SEL=4'b0101, STALL_CNT=0.
2. `lw x5` followed by `add x6,x5,x0`: one cycle with IDEX_FLUSH=1, IFID_EN=0, PC_WRITE=0; FWD_SEL[1:0]=2 next cycle; STALL_CNT=1.
3. Same as 1 with FWD_EN=0: 3 bubble cycles, FWD_SEL=0, STALL_CNT=3.
4. DMEM_START then DMEM_DONE 4 cycles later, IMEM_DONE arriving at cycle 2: freeze exactly 4 cycles, imem_q holds, all latches clear on advance.
5. REDIRECT coinciding with a load-use hazard: IFID_FLUSH=IDEX_FLUSH=1, PC_WRITE=1, FLUSH_CNT=1, STALL_CNT unchanged.
6. Source address x0 with EX_WADDR=0 and EX_WVALID=1: no match, FWD_SEL=0; NRST low for 1 cycle during WAIT returns the FSM to RUN with counters cleared.
